// File: rtl/chi_tx_lcrd_flit_ctrl.sv
// CHI TX flit channel controller.
// Runs downstream of the link activation FSM. It gates protocol flits on
// link-layer credits (L-credits) granted by the remote receiver. When the link
// deactivates, it returns every held credit as a link flit and then signals
// that the link FSM may enter TxStop.
module chi_tx_lcrd_flit_ctrl #(
  parameter int FLIT_W      = 128,
  parameter int MAX_CREDITS = 15,
  parameter int CW          = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [2:0]        tx_link_state,
  input  logic              req_valid,
  input  logic [FLIT_W-1:0] req_flit,
  output logic              req_ready,
  input  logic              txlcrdv,
  output logic              txflitpend,
  output logic              txflitv,
  output logic [FLIT_W-1:0] txflit,
  output logic              link_flit,
  output logic [CW-1:0]     credit_cnt,
  output logic              deact_done,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RETURN = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Only these link states affect the controller.
  localparam logic [2:0]    TX_STOP  = 3'd0;
  localparam logic [2:0]    TX_RUN   = 3'd4;
  localparam logic [2:0]    TX_DEACT = 3'd5;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CREDITS);

  state_t              state_r;
  state_t              state_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_s;
  logic                proto_err_r;
  logic                grant_err_s;
  logic                stop_err_s;
  logic                req_ready_s;
  logic                proto_send_s;
  logic                link_send_s;
  logic                sent_s;
  logic                txflitv_r;
  logic                link_flit_r;
  logic [FLIT_W-1:0]   txflit_r;
  logic                txflitpend_r;
  logic                deact_done_r;

  // Send qualification: protocol flits need a credit in RUN, link flits drain credits in RETURN.
  always_comb begin
    req_ready_s  = (state_r == ST_RUN) && (cnt_r != CNT_ZERO);
    proto_send_s = req_valid && req_ready_s;
    link_send_s  = (state_r == ST_RETURN) && (cnt_r != CNT_ZERO);
    sent_s       = proto_send_s || link_send_s;
  end

  // Credit counter next value and protocol error detection.
  always_comb begin
    cnt_s       = cnt_r;
    grant_err_s = 1'b0;
    if ((state_r == ST_RUN) || (state_r == ST_RETURN)) begin
      if (txlcrdv && !sent_s && (cnt_r == CNT_MAX)) begin
        // Remote over-granted: hold at the limit and flag it.
        cnt_s       = cnt_r;
        grant_err_s = 1'b1;
      end else begin
        cnt_s       = cnt_r + {{(CW-1){1'b0}}, txlcrdv} - {{(CW-1){1'b0}}, sent_s};
        grant_err_s = 1'b0;
      end
    end else begin
      // Credits are not expected outside RUN/RETURN; they are dropped.
      cnt_s       = cnt_r;
      grant_err_s = txlcrdv;
    end
    // Entering TxStop early discards held credits, which is an error if any remain.
    stop_err_s = (tx_link_state == TX_STOP) && (cnt_r != CNT_ZERO);
    if (tx_link_state == TX_STOP) begin
      cnt_s = CNT_ZERO;
    end else begin
      cnt_s = cnt_s;
    end
  end

  // Next-state logic; TxStop forces IDLE from every state.
  always_comb begin
    state_s = state_r;
    if (tx_link_state == TX_STOP) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_s = (tx_link_state == TX_RUN) ? ST_RUN : ST_IDLE;
        ST_RUN:    state_s = (tx_link_state == TX_DEACT) ? ST_RETURN : ST_RUN;
        ST_RETURN: state_s = ((cnt_r == CNT_ZERO) && !txlcrdv) ? ST_DONE : ST_RETURN;
        ST_DONE:   state_s = ST_DONE;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Control state: FSM, credit count and sticky error.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      proto_err_r <= proto_err_r || grant_err_s || stop_err_s;
    end
  end

  // Channel outputs: one-cycle flit latency, payload holds when idle.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      txflitv_r    <= 1'b0;
      link_flit_r  <= 1'b0;
      txflit_r     <= {FLIT_W{1'b0}};
      txflitpend_r <= 1'b0;
      deact_done_r <= 1'b0;
    end else begin
      txflitv_r   <= sent_s;
      link_flit_r <= link_send_s;
      if (proto_send_s) begin
        txflit_r <= req_flit;
      end else if (link_send_s) begin
        txflit_r <= {FLIT_W{1'b0}};
      end else begin
        txflit_r <= txflit_r;
      end
      txflitpend_r <= (state_s == ST_RUN) || (state_s == ST_RETURN);
      deact_done_r <= (state_s == ST_DONE);
    end
  end

  assign req_ready  = req_ready_s;
  assign txflitv    = txflitv_r;
  assign link_flit  = link_flit_r;
  assign txflit     = txflit_r;
  assign txflitpend = txflitpend_r;
  assign deact_done = deact_done_r;
  assign credit_cnt = cnt_r;
  assign proto_err  = proto_err_r;

endmodule

// File: doc/chi_tx_lcrd_flit_ctrl.md
Name: chi_tx_lcrd_flit_ctrl

Overview:
- TX-side flit channel controller, directly downstream of the CHI link activation FSM.
- Consumes the TX link state and gates protocol flit transmission on link-layer credits (L-credits) received from the remote RX.
- On link deactivation it returns every held credit as link flits, then reports completion so the link FSM can move to TxStop.

Parameters:
- FLIT_W, 128, width of flit payload.
- MAX_CREDITS, 15, maximum L-credits held (CHI limit).
- CW, 4, credit counter width; must satisfy 2**CW > MAX_CREDITS.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous, active-low reset.
- tx_link_state  in  3  TX link state: TxStop=0, TxActp=1, TxAct=2, TxRunp=3, TxRun=4, TxDeact=5, TxDeactp=6, TxStopp=7.
- req_valid  in  1  upstream protocol flit valid.
- req_flit  in  FLIT_W  upstream protocol flit.
- req_ready  out  1  flit accepted this cycle.
- txlcrdv  in  1  one L-credit granted by remote, per cycle high.
- txflitpend  out  1  flit may be sent next cycle.
- txflitv  out  1  flit valid on channel.
- txflit  out  FLIT_W  flit payload.
- link_flit  out  1  qualifies txflitv: credit-return link flit.
- credit_cnt  out  CW  credits currently held.
- deact_done  out  1  all credits returned, safe to enter TxStop.
- proto_err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - Outputs: txflitv=0, txflitpend=0, link_flit=0, txflit=0, req_ready=0, credit_cnt=0, deact_done=0, proto_err=0.
  - FSM state: IDLE.
- FSM states: IDLE, RUN, RETURN, DONE.
  - IDLE -> RUN when tx_link_state==TxRun.
  - RUN -> RETURN when tx_link_state==TxDeact.
  - RETURN -> DONE when credit_cnt==0 and txlcrdv==0.
  - DONE -> IDLE when tx_link_state==TxStop.
  - Any state other than IDLE -> IDLE when tx_link_state==TxStop before DONE is reached; credit_cnt cleared to 0; proto_err set if credit_cnt!=0.
- Credit counter, next value = cnt + txlcrdv - sent:
  - sent = protocol handshake in RUN, or link flit issued in RETURN.
  - Simultaneous grant and send: count unchanged.
  - txlcrdv accepted only in RUN and RETURN. In IDLE/DONE it is ignored and sets proto_err.
  - txlcrdv with credit_cnt==MAX_CREDITS and no send in the same cycle: count saturates and proto_err is set.
- Protocol send (RUN only):
  - req_ready = (state==RUN) && (credit_cnt!=0), combinational, independent of txlcrdv.
  - Handshake = req_valid && req_ready.
  - Next cycle: txflitv=1, txflit=req_flit, link_flit=0. Latency is 1 cycle, back-to-back every cycle while credits last.
  - No handshake: txflitv=0 next cycle; txflit holds its last value.
- Credit return (RETURN):
  - Each cycle with credit_cnt!=0: issue a link flit. Next cycle txflitv=1, link_flit=1, txflit=0.
  - Decrement counter.
  - req_ready=0.
  - A txlcrdv arriving in RETURN is counted and also returned.
- txflitpend: high in RUN and RETURN; low in IDLE/DONE. Held high is legal, so it always precedes txflitv by >=1 cycle.
- deact_done: registered, 1 in DONE only.
- proto_err: cleared only by reset.
- Reset mid-operation: everything returns to reset values at the next ACLK edge. A flit in flight is dropped.

Test Plan:
1. Reset, tx_link_state=TxRun, pulse txlcrdv 3 cycles, req_valid=1 held, then tx_link_state=TxDeact.
   - credit_cnt reaches 3.
   - Exactly 3 txflitv with link_flit=0.
   - After credits are exhausted, req_ready=0 and credit_cnt=0.
2. In RUN with credit_cnt=2, txlcrdv and req_valid both high for 1 cycle -> credit_cnt stays 2 and one flit is sent the next cycle.
3. credit_cnt=5, tx_link_state=TxDeact, txlcrdv once during return:
   - 6 consecutive link flits (txflitv=1, link_flit=1, txflit=0).
   - deact_done=1 the cycle after return completes.
   - tx_link_state=TxStop -> IDLE, deact_done=0.
4. Grant 16 credits with MAX_CREDITS=15 and no sends -> credit_cnt=15, proto_err=1 and sticky.
5. credit_cnt=4 in RUN, tx_link_state jumps to TxStop -> IDLE, credit_cnt=0, proto_err=1; txlcrdv in IDLE also sets proto_err.
6. Assert ARESETn=0 mid-return with credit_cnt=3 -> next cycle all outputs at reset values, state IDLE.
